// File: rtl/waveform_mixer.sv
// rtl/waveform_mixer.sv - six-channel gain-weighted mixer with saturated, registered 8-bit output
// Define WAVEFORM_MIXER_ROUND_EN to select round-half-up scaling instead of truncation.
module waveform_mixer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] square_in,
  input  logic [7:0] sawtooth_in,
  input  logic [7:0] triangle_in,
  input  logic [7:0] sine_in,
  input  logic [7:0] noise_in,
  input  logic [7:0] wavetable_in,
  input  logic [7:0] gain_square,
  input  logic [7:0] gain_sawtooth,
  input  logic [7:0] gain_triangle,
  input  logic [7:0] gain_sine,
  input  logic [7:0] gain_noise,
  input  logic [7:0] gain_wavetable,
  output logic [7:0] mixed_out
);

  logic [15:0] p_square, p_sawtooth, p_triangle, p_sine, p_noise, p_wavetable;
  logic [18:0] sum;
  logic [18:0] scaled_sum;
  logic [10:0] q;
  logic [7:0]  sat;

  assign p_square    = square_in    * gain_square;
  assign p_sawtooth  = sawtooth_in  * gain_sawtooth;
  assign p_triangle  = triangle_in  * gain_triangle;
  assign p_sine      = sine_in      * gain_sine;
  assign p_noise     = noise_in     * gain_noise;
  assign p_wavetable = wavetable_in * gain_wavetable;

  // 19 bits hold 6 * 65025 + 128 without wrapping.
  assign sum = {3'b000, p_square} + {3'b000, p_sawtooth} + {3'b000, p_triangle}
             + {3'b000, p_sine} + {3'b000, p_noise} + {3'b000, p_wavetable};

`ifdef WAVEFORM_MIXER_ROUND_EN
  assign scaled_sum = sum + 19'd128;
`else
  assign scaled_sum = sum;
`endif

  assign q   = scaled_sum[18:8];
  assign sat = (q > 11'd255) ? 8'hFF : q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mixed_out <= 8'h00;
    else     mixed_out <= sat;
  end

endmodule

// File: tb/tb_waveform_mixer.sv
// tb/tb_waveform_mixer.sv - directed and randomized self-checking bench for waveform_mixer
module tb_waveform_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_v   [6];
  logic [7:0] gain_v [6];
  logic [7:0] mixed_out;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  waveform_mixer dut (
    .clk(clk), .rst(rst),
    .square_in(in_v[0]), .sawtooth_in(in_v[1]), .triangle_in(in_v[2]),
    .sine_in(in_v[3]), .noise_in(in_v[4]), .wavetable_in(in_v[5]),
    .gain_square(gain_v[0]), .gain_sawtooth(gain_v[1]), .gain_triangle(gain_v[2]),
    .gain_sine(gain_v[3]), .gain_noise(gain_v[4]), .gain_wavetable(gain_v[5]),
    .mixed_out(mixed_out)
  );

  // Reference: weighted sum, divide by 256, clamp to 255.
  function automatic logic [7:0] model();
    int s = 0;
    int q;
    for (int i = 0; i < 6; i++) s += int'(in_v[i]) * int'(gain_v[i]);
`ifdef WAVEFORM_MIXER_ROUND_EN
    s += 128;
`endif
    q = s / 256;
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    compared++;
    assert (mixed_out === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%02h expected=%02h", tag, mixed_out, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] iv, input logic [7:0] gv);
    for (int i = 0; i < 6; i++) begin
      in_v[i] = iv;
      gain_v[i] = gv;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_v;
    set_all(8'h00, 8'h00);
    rst = 1'b1;
    step();
    step();
    check("reset_state", 8'h00);

    // Asynchronous reset with full-scale operands
    set_all(8'hFF, 8'hFF);
    step();
    check("reset_held_full_inputs", 8'h00);
    rst = 1'b0;
    step();
    check("reset_release", 8'hFF);
    #2 rst = 1'b1;
    #1 check("reset_async_mid_cycle", 8'h00);
    step();
    check("reset_held", 8'h00);
    rst = 1'b0;
    step();
    check("reset_release_again", 8'hFF);

    // Single channel
    set_all(8'h00, 8'h00);
    in_v[0] = 8'hFF; gain_v[0] = 8'hFF;
    step();
    check("single_full_scale", 8'hFE);
    gain_v[0] = 8'h80;
    step();
`ifdef WAVEFORM_MIXER_ROUND_EN
    check("single_half_gain", 8'h80);
`else
    check("single_half_gain", 8'h7F);
`endif
    set_all(8'h00, 8'h00);
    in_v[3] = 8'hFF; gain_v[3] = 8'h40;
    step();
`ifdef WAVEFORM_MIXER_ROUND_EN
    check("single_sine_quarter", 8'h40);
`else
    check("single_sine_quarter", 8'h3F);
`endif

    set_all(8'hFF, 8'h00);
    step();
    check("mute", 8'h00);

    set_all(8'h00, 8'h00);
    in_v[0] = 8'h80; in_v[3] = 8'h80; gain_v[0] = 8'h80; gain_v[3] = 8'h80;
    step();
    check("two_channel", 8'h80);

    set_all(8'hC0, 8'h2A);
    step();
    check("six_way", 8'hBD);

    set_all(8'hFF, 8'hFF);
    step();
    check("saturate_full", 8'hFF);
    for (int i = 0; i < 6; i++) in_v[i] = 8'(8'h10 * (i + 1));
    step();
    check("saturate_no_wrap", 8'hFF);

    // Each channel alone, to catch miswired or dropped channels
    for (int c = 0; c < 6; c++) begin
      set_all(8'h00, 8'h00);
      in_v[c] = 8'(8'h31 + 8'(c * 23));
      gain_v[c] = 8'(8'hE7 - 8'(c * 17));
      exp_v = model();
      step();
      check($sformatf("channel_%0d_alone", c), exp_v);
    end

    // Randomized operand sets, biased between quiet and loud gains
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 6; i++) begin
        in_v[i] = 8'($urandom_range(0, 255));
        gain_v[i] = (n % 3 == 0) ? 8'($urandom_range(0, 64)) : 8'($urandom_range(0, 255));
      end
      exp_v = model();
      step();
      check($sformatf("random_%0d", n), exp_v);
    end

    // Reset in the middle of random traffic clears everything
    #2 rst = 1'b1;
    #1 check("reset_mid_random", 8'h00);
    set_all(8'h55, 8'hAA);
    exp_v = model();
    step();
    check("reset_mid_random_held", 8'h00);
    rst = 1'b0;
    step();
    check("reset_mid_random_release", exp_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
